// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel rise/fall FSM, one-cycle ticks, sticky pending flags, irq.
// Optional input synchroniser is compiled in with EDGE_DET_SYNC_EN (SYNC_STAGES deep).
module edge_detect_multi #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] level,
    input  logic [W-1:0] mode_rise,
    input  logic [W-1:0] mode_fall,
    input  logic [W-1:0] clr,
    input  logic [W-1:0] irq_en,
    output logic [W-1:0] tick,
    output logic [W-1:0] event_pend,
    output logic         irq
);

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        RISE = 2'b01,
        ONE  = 2'b11,
        FALL = 2'b10
    } state_t;

    logic [W-1:0] samp;
    state_t       state_q [W];
    state_t       state_d [W];
    logic [W-1:0] pend_q;
    logic [W-1:0] pend_d;

`ifdef EDGE_DET_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q [W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < W; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], level[i]};
            end
        end
    end

    always_comb begin
        samp = '0;
        for (int i = 0; i < W; i++) begin
            samp[i] = sync_q[i][SYNC_STAGES-1];
        end
    end
`else
    // Depth only matters when the synchroniser is built.
    logic unused_sync_cfg;
    assign unused_sync_cfg = (SYNC_STAGES != 0);
    assign samp = level;
`endif

    always_comb begin
        for (int i = 0; i < W; i++) begin
            state_d[i] = ZERO;
            case (state_q[i])
                ZERO:    state_d[i] = samp[i] ? RISE : ZERO;
                RISE:    state_d[i] = samp[i] ? ONE  : FALL;
                ONE:     state_d[i] = samp[i] ? ONE  : FALL;
                FALL:    state_d[i] = samp[i] ? RISE : ZERO;
                default: state_d[i] = ZERO;
            endcase
        end
    end

    // Ticks decode registered state only; mode bits just gate the output.
    always_comb begin
        tick = '0;
        for (int i = 0; i < W; i++) begin
            tick[i] = ((state_q[i] == RISE) && mode_rise[i]) ||
                      ((state_q[i] == FALL) && mode_fall[i]);
        end
    end

    // A tick in the same cycle as clr keeps the flag set.
    assign pend_d = (pend_q & ~clr) | tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < W; i++) begin
                state_q[i] <= ZERO;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                state_q[i] <= state_d[i];
            end
            pend_q <= pend_d;
        end
    end

    assign event_pend = pend_q;
    assign irq        = |(pend_q & irq_en);

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus randomized traffic against an edge-history model.
module tb_edge_detect_multi;

    localparam int W           = 8;
    localparam int SYNC_STAGES = 2;
`ifdef EDGE_DET_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] level;
    logic [W-1:0] mode_rise;
    logic [W-1:0] mode_fall;
    logic [W-1:0] clr;
    logic [W-1:0] irq_en;
    logic [W-1:0] tick;
    logic [W-1:0] event_pend;
    logic         irq;

    int n_pass  = 0;
    int n_total = 0;

    // Model: sampled level is the input delayed LAT edges; an edge is seen
    // when the current sample differs from the previous one.
    logic [W-1:0] m_dl [$];
    logic [W-1:0] m_prev;
    logic [W-1:0] m_cur;
    logic [W-1:0] m_pend;

    edge_detect_multi #(.W(W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .level      (level),
        .mode_rise  (mode_rise),
        .mode_fall  (mode_fall),
        .clr        (clr),
        .irq_en     (irq_en),
        .tick       (tick),
        .event_pend (event_pend),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_tick();
        return (m_cur & ~m_prev & mode_rise) | (~m_cur & m_prev & mode_fall);
    endfunction

    task automatic model_reset();
        m_dl.delete();
        for (int k = 0; k < LAT; k++) m_dl.push_back('0);
        m_prev = '0;
        m_cur  = '0;
        m_pend = '0;
    endtask

    task automatic step();
        logic [W-1:0] t;
        logic [W-1:0] sv;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            t      = model_tick();
            m_pend = (m_pend & ~clr) | t;
            m_dl.push_back(level);
            sv     = m_dl.pop_front();
            m_prev = m_cur;
            m_cur  = sv;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; level = '0; mode_rise = '0; mode_fall = '0; clr = '0; irq_en = '0;
        model_reset();
        step(); step();
        n_total++;
        if (tick !== '0 || event_pend !== '0 || irq !== 1'b0) begin
            $display("FAIL reset_state tick=%h pend=%h irq=%b required 00/00/0", tick, event_pend, irq);
        end else n_pass++;
        reset_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) step();
    endtask

    task automatic test_rise_latency();
        mode_rise = 8'hFF; mode_fall = 8'h00; irq_en = 8'h00;
        level[3] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            n_total++;
            if (k == LAT + 1 && tick !== 8'h08) begin
                $display("FAIL rise_tick step=%0d tick=%h required 08", k, tick);
            end else if (k != LAT + 1 && tick !== 8'h00) begin
                $display("FAIL rise_quiet step=%0d tick=%h required 00", k, tick);
            end else n_pass++;
        end
        n_total++;
        if (event_pend !== 8'h08 || event_pend !== m_pend) begin
            $display("FAIL rise_pend pend=%h required 08 (model %h)", event_pend, m_pend);
        end else n_pass++;
    endtask

    task automatic test_pulse();
        mode_rise = 8'h01; mode_fall = 8'h01;
        level[0] = 1'b1;
        step();
        level[0] = 1'b0;
        for (int k = 2; k < LAT + 1; k++) step();
        for (int k = 0; k < 2; k++) begin
            if (LAT > 0 || k > 0) step();
            n_total++;
            if (tick !== 8'h01 || tick !== model_tick()) begin
                $display("FAIL pulse_tick%0d tick=%h required 01", k, tick);
            end else n_pass++;
        end
        step();
        n_total++;
        if (event_pend[0] !== 1'b1 || tick !== 8'h00) begin
            $display("FAIL pulse_after pend0=%b tick=%h required 1/00", event_pend[0], tick);
        end else n_pass++;
    endtask

    task automatic test_clr_collision();
        mode_rise = 8'h01; mode_fall = 8'h00; irq_en = 8'h01;
        level[0] = 1'b1;
        for (int k = 0; k < LAT + 1; k++) step();
        n_total++;
        if (tick[0] !== 1'b1) $display("FAIL coll_tick tick0=%b required 1", tick[0]);
        else n_pass++;
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        n_total++;
        if (event_pend[0] !== 1'b1 || irq !== 1'b1) begin
            $display("FAIL coll_setwins pend0=%b irq=%b required 1/1", event_pend[0], irq);
        end else n_pass++;
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        n_total++;
        if (event_pend[0] !== 1'b0 || irq !== 1'b0 || event_pend !== m_pend) begin
            $display("FAIL clr_only pend=%h irq=%b required pend0=0 irq=0 (model %h)", event_pend, irq, m_pend);
        end else n_pass++;
    endtask

    task automatic test_fall_only();
        int cnt;
        int at;
        mode_rise = 8'hDF; mode_fall = 8'h20;
        cnt = 0; at = -1;
        level[5] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick[5]) cnt++;
        end
        n_total++;
        if (cnt != 0) $display("FAIL fall_norise ticks=%0d required 0", cnt);
        else n_pass++;
        level[5] = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            if (tick[5]) begin cnt++; at = k; end
            n_total++;
            if (tick !== model_tick()) $display("FAIL fall_model step=%0d tick=%h required %h", k, tick, model_tick());
            else n_pass++;
        end
        n_total++;
        if (cnt != 1 || at != LAT + 1) $display("FAIL fall_once ticks=%0d at=%0d required 1 at %0d", cnt, at, LAT + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            level     = W'($urandom_range(0, 3) == 0 ? $urandom : {level[W-2:0], level[W-1]});
            mode_rise = W'($urandom);
            mode_fall = W'($urandom);
            irq_en    = W'($urandom);
            clr       = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            #1;
            n_total++;
            if (tick !== model_tick() || event_pend !== m_pend || irq !== |(m_pend & irq_en)) begin
                $display("FAIL random cyc=%0d tick=%h pend=%h irq=%b required %h/%h/%b",
                         k, tick, event_pend, irq, model_tick(), m_pend, |(m_pend & irq_en));
            end else n_pass++;
            step();
        end
        clr = '0;
    endtask

    task automatic test_reset_high();
        int hits;
        int bad;
        reset_n = 1'b0;
        model_reset();
        level = 8'hFF; mode_rise = 8'hFF; mode_fall = 8'h00; clr = '0; irq_en = 8'hFF;
        step(); step(); step();
        reset_n = 1'b1;
        hits = 0; bad = 0;
        for (int k = 1; k <= LAT + 12; k++) begin
            step();
            if (k == LAT + 1) begin
                if (tick === 8'hFF) hits++;
            end else if (tick !== 8'h00) bad++;
        end
        n_total++;
        if (hits != 1 || bad != 0) $display("FAIL reset_high hits=%0d stray=%0d required 1/0", hits, bad);
        else n_pass++;
        n_total++;
        if (event_pend !== 8'hFF || irq !== 1'b1) $display("FAIL reset_high_pend pend=%h irq=%b required FF/1", event_pend, irq);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int bad;
        level = 8'h00; mode_rise = 8'hFF; mode_fall = 8'h00; irq_en = 8'hFF;
        for (int k = 0; k < LAT + 3; k++) step();
        level[2] = 1'b1;
        for (int k = 0; k < LAT + 1; k++) step();
        n_total++;
        if (tick !== 8'h04) $display("FAIL arst_pre tick=%h required 04", tick);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (tick !== '0 || event_pend !== '0 || irq !== 1'b0) begin
            $display("FAIL arst_now tick=%h pend=%h irq=%b required 00/00/0", tick, event_pend, irq);
        end else n_pass++;
        level = 8'h00;
        step(); step();
        reset_n = 1'b1;
        bad = 0;
        for (int k = 0; k < LAT + 10; k++) begin
            step();
            if (tick !== 8'h00) bad++;
        end
        n_total++;
        if (bad != 0 || event_pend !== 8'h00) $display("FAIL arst_after stray=%0d pend=%h required 0/00", bad, event_pend);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_pulse();
        test_clr_collision();
        test_fall_only();
        test_random();
        test_reset_high();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
